// File: rtl/apb_fabric_n_if.sv
// APB bus bundles used by apb_fabric_n.
//
// apb_core_if : initiator-side APB (one initiator, one responder).
//   master modport = the core initiator, slave modport = the fabric.
// apb_tgt_if  : shared target-side APB with one psel/pready/pslverr bit per
//   target and a flattened read-data bus (target 0 in the LSBs).
//   master modport = the fabric, slave modport = the target collection.
//
// Handshake: a transfer starts with a SETUP cycle (psel=1, penable=0),
// followed by one or more ACCESS cycles (psel=1, penable=1). The request
// signals are held stable from SETUP until the cycle where pready=1. That
// cycle completes the transfer, and prdata/pslverr are only meaningful then.
interface apb_core_if #(
    parameter int ADDR_W = 34
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [3:0]        pwstrb;
    logic              pready;
    logic              pslverr;
    logic [31:0]       prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pwstrb,
        input  pready, pslverr, prdata
    );
    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pwstrb,
        output pready, pslverr, prdata
    );
endinterface

interface apb_tgt_if #(
    parameter int N_TGT      = 4,
    parameter int TGT_ADDR_W = 31
);
    logic [N_TGT-1:0]      psel;
    logic                  penable;
    logic                  pwrite;
    logic [TGT_ADDR_W-1:0] paddr;
    logic [31:0]           pwdata;
    logic [3:0]            pwstrb;
    logic [N_TGT-1:0]      pready;
    logic [N_TGT-1:0]      pslverr;
    logic [N_TGT*32-1:0]   prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pwstrb,
        input  pready, pslverr, prdata
    );
    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pwstrb,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb_fabric_n.sv
// apb_fabric_n: N-target APB decoder/router.
//
// Decodes the initiator address against per-target base/mask pairs (lowest
// index wins on overlap), routes the request to the hit target and the
// response back. Unmapped accesses get a zero-wait-state error response, and
// a target that stalls the ACCESS phase for TIMEOUT_CYC cycles is abandoned
// with an error response (TIMEOUT_CYC=0 disables this).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   core_i       initiator-side APB (slave modport)
//   t            shared target-side APB (master modport)
//   err_valid    one-cycle pulse, the cycle after a fabric error response
//   err_code     0 = decode error, 1 = timeout (held until next error)
//   err_addr     initiator address of the last erroring transfer
//   err_cnt      saturating count of fabric errors
//   dbg_state    current FSM state (0 IDLE, 1 ACCESS, 2 ERR)
module apb_fabric_n #(
    parameter int N_TGT      = 4,
    parameter int ADDR_W     = 34,
    parameter int TGT_ADDR_W = 31,
    parameter logic [N_TGT*ADDR_W-1:0] TGT_BASE =
        {34'h0_9000_0000, 34'h0_8001_0000, 34'h0_8000_0000, 34'h0_0000_0000},
    parameter logic [N_TGT*ADDR_W-1:0] TGT_MASK =
        {34'h3_fc00_0000, 34'h3_ffff_0000, 34'h3_ffff_f000, 34'h3_8000_0000},
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    apb_core_if.slave         core_i,
    apb_tgt_if.master         t,
    output logic              err_valid,
    output logic              err_code,
    output logic [ADDR_W-1:0] err_addr,
    output logic [7:0]        err_cnt,
    output logic [1:0]        dbg_state
);

    localparam int IDX_W  = (N_TGT > 1) ? $clog2(N_TGT) : 1;
    localparam int WDOG_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST =
        (TIMEOUT_CYC > 0) ? WDOG_W'(TIMEOUT_CYC - 1) : WDOG_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_vld;
    logic [WDOG_W-1:0] wdog;

    logic              live_hit;
    logic [IDX_W-1:0]  live_idx;
    logic [IDX_W-1:0]  cur_idx;
    logic              tgt_ready;
    logic              wdog_expire;
    logic              fab_err;
    logic              fab_code;

    assign dbg_state = state;

    // Live decode. Scanning from the top index down lets the lowest matching
    // index overwrite the others, which gives the overlap priority.
    always_comb begin
        live_hit = 1'b0;
        live_idx = '0;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if ((core_i.paddr & TGT_MASK[i*ADDR_W +: ADDR_W]) == TGT_BASE[i*ADDR_W +: ADDR_W]) begin
                live_hit = 1'b1;
                live_idx = IDX_W'(i);
            end
        end
    end

    // In IDLE the SETUP-phase address is decoded live so psel/paddr reach the
    // target with no added latency; afterwards the latched index is used.
    assign cur_idx = (state == ST_IDLE) ? live_idx : sel_idx;

    always_comb begin
        t.psel = '0;
        if (core_i.psel) begin
            if (state == ST_IDLE && live_hit) begin
                t.psel = N_TGT'(1) << live_idx;
            end else if (state == ST_ACCESS && sel_vld) begin
                t.psel = N_TGT'(1) << sel_idx;
            end
        end
    end

    assign t.paddr   = TGT_ADDR_W'(core_i.paddr & ~TGT_MASK[cur_idx*ADDR_W +: ADDR_W]);
    assign t.penable = core_i.penable;
    assign t.pwrite  = core_i.pwrite;
    assign t.pwdata  = core_i.pwdata;
    assign t.pwstrb  = core_i.pwstrb;

    assign tgt_ready   = t.pready[sel_idx];
    assign wdog_expire = (TIMEOUT_CYC != 0) && (wdog == WDOG_LAST) && !tgt_ready;

    // Response mux. A fabric error (decode miss or watchdog) overrides the
    // target response with pready=1, pslverr=1, prdata=0.
    always_comb begin
        core_i.pready  = 1'b0;
        core_i.pslverr = 1'b0;
        core_i.prdata  = '0;
        fab_err        = 1'b0;
        fab_code       = 1'b0;
        if (core_i.psel) begin
            case (state)
                ST_ACCESS: begin
                    if (wdog_expire) begin
                        core_i.pready  = 1'b1;
                        core_i.pslverr = 1'b1;
                        fab_err        = 1'b1;
                        fab_code       = 1'b1;
                    end else begin
                        core_i.pready  = tgt_ready;
                        core_i.pslverr = t.pslverr[sel_idx];
                        core_i.prdata  = t.prdata[sel_idx*32 +: 32];
                    end
                end
                ST_ERR: begin
                    core_i.pready  = 1'b1;
                    core_i.pslverr = 1'b1;
                    fab_err        = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sel_idx   <= '0;
            sel_vld   <= 1'b0;
            wdog      <= '0;
            err_valid <= 1'b0;
            err_code  <= 1'b0;
            err_addr  <= '0;
            err_cnt   <= '0;
        end else begin
            err_valid <= fab_err;
            if (fab_err) begin
                err_code <= fab_code;
                err_addr <= core_i.paddr;
                if (err_cnt != 8'hff) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (core_i.psel && !core_i.penable) begin
                        sel_idx <= live_idx;
                        sel_vld <= live_hit;
                        wdog    <= '0;
                        state   <= live_hit ? ST_ACCESS : ST_ERR;
                    end
                end
                ST_ACCESS: begin
                    // A dropped psel is an initiator violation: abandon quietly.
                    if (!core_i.psel || tgt_ready || wdog_expire) begin
                        state <= ST_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_ERR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_fabric_n.sv
// Testbench for apb_fabric_n (4 targets, 34-bit initiator address,
// TIMEOUT_CYC=256). The bench plays both the initiator and the targets:
// a table of transfers is applied in a loop, expected responses are queued
// when each transfer is driven and compared when core_i.pready rises, and
// hand-written sequences cover back-to-back SETUP, error-count saturation
// and reset in the middle of a transfer.
`timescale 1ns/1ps
module tb_apb_fabric_n;

    localparam int N_TGT      = 4;
    localparam int ADDR_W     = 34;
    localparam int TGT_ADDR_W = 31;
    localparam int TMO        = 256;

    typedef struct {
        logic [ADDR_W-1:0]     addr;
        logic                  wr;
        logic [31:0]           wdata;
        logic [3:0]            strb;
        int                    tgt;    // -1 = unmapped
        logic [TGT_ADDR_W-1:0] paddr;  // expected target address
        int                    waits;  // >= TMO means the target never answers
        logic [31:0]           rdata;
        logic                  terr;   // target reports pslverr
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    apb_core_if #(.ADDR_W(ADDR_W)) core_i();
    apb_tgt_if #(.N_TGT(N_TGT), .TGT_ADDR_W(TGT_ADDR_W)) t();

    logic              err_valid;
    logic              err_code;
    logic [ADDR_W-1:0] err_addr;
    logic [7:0]        err_cnt;
    logic [1:0]        dbg_state;

    apb_fabric_n #(
        .N_TGT(N_TGT),
        .ADDR_W(ADDR_W),
        .TGT_ADDR_W(TGT_ADDR_W),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .core_i(core_i),
        .t(t),
        .err_valid(err_valid),
        .err_code(err_code),
        .err_addr(err_addr),
        .err_cnt(err_cnt),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];          // {pslverr, prdata}
    int exp_cnt = 0;                // model of err_cnt
    logic last_err = 1'b0;
    logic last_code = 1'b0;
    logic [ADDR_W-1:0] last_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic xfer(input vec_t v, input bit b2b);
        logic [32:0]         exp_rsp;
        logic [N_TGT*32-1:0] rd_bus;
        logic [N_TGT-1:0]    exp_sel;
        logic                fab_err;
        int                  exp_cyc;
        bit                  done;
        fab_err = (v.tgt < 0) || (v.waits >= TMO);
        exp_cyc = (v.tgt < 0) ? 0 : ((v.waits >= TMO) ? TMO - 1 : v.waits);
        exp_sel = (v.tgt < 0) ? '0 : (N_TGT'(1) << v.tgt);
        for (int i = 0; i < N_TGT; i++) begin
            rd_bus[i*32 +: 32] = (i == v.tgt) ? v.rdata : (32'hbad0_0000 | 32'(i));
        end
        exp_rsp = fab_err ? {1'b1, 32'h0} : {v.terr, v.rdata};

        // SETUP
        @(negedge clk);
        core_i.psel    = 1'b1;
        core_i.penable = 1'b0;
        core_i.pwrite  = v.wr;
        core_i.paddr   = v.addr;
        core_i.pwdata  = v.wdata;
        core_i.pwstrb  = v.strb;
        t.pready       = '0;
        t.pslverr      = v.terr ? exp_sel : '0;
        t.prdata       = rd_bus;
        exp_q.push_back(exp_rsp);
        #1;
        check("setup_psel", t.psel, exp_sel);
        if (v.tgt >= 0) check("setup_paddr", t.paddr, v.paddr);
        check("setup_pass", {t.penable, t.pwrite, t.pwstrb, t.pwdata}, {1'b0, v.wr, v.strb, v.wdata});
        check("setup_pready", core_i.pready, 1'b0);
        check("setup_err_valid", err_valid, b2b ? last_err : 1'b0);

        // ACCESS
        done = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            core_i.penable = 1'b1;
            t.pready = (cyc == v.waits) ? exp_sel : '0;
            #1;
            check("access_psel", t.psel, exp_sel);
            if (core_i.pready) begin
                done = 1'b1;
                check("rsp_cycle", cyc, exp_cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected actual=%0h required=none", {core_i.pslverr, core_i.prdata});
                end else begin
                    check("rsp_data", {core_i.pslverr, core_i.prdata}, exp_q.pop_front());
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout addr=%0h actual=no_pready required=pready", v.addr);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        last_err  = fab_err;
        last_code = (v.tgt >= 0);
        if (fab_err) last_addr = v.addr;
        if (fab_err && exp_cnt < 255) exp_cnt++;
    endtask

    task automatic idle_check();
        @(negedge clk);
        core_i.psel    = 1'b0;
        core_i.penable = 1'b0;
        t.pready       = '0;
        #1;
        check("idle_psel", t.psel, '0);
        check("idle_pready", core_i.pready, 1'b0);
        check("err_valid", err_valid, last_err);
        if (last_err) begin
            check("err_code", err_code, last_code);
            check("err_addr", err_addr, last_addr);
        end
        check("err_cnt", err_cnt, exp_cnt);
        last_err = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[9];
    vec_t v;

    initial begin
        vecs[0] = '{34'h0_0000_1000, 1'b0, 32'h0,         4'h0, 0,  31'h1000,      2,   32'hdead_beef, 1'b0};
        vecs[1] = '{34'h0_8001_0008, 1'b1, 32'h1234_5678, 4'hf, 2,  31'h0008,      0,   32'h0bad_cafe, 1'b0};
        vecs[2] = '{34'h0_a000_0000, 1'b0, 32'h0,         4'h0, -1, 31'h0,         0,   32'h0,         1'b0};
        vecs[3] = '{34'h0_8000_0ffc, 1'b0, 32'h0,         4'h0, 1,  31'h0ffc,      1,   32'hcafe_f00d, 1'b1};
        vecs[4] = '{34'h2_0000_0010, 1'b1, 32'h5555_aaaa, 4'h3, -1, 31'h0,         0,   32'h0,         1'b0};
        vecs[5] = '{34'h0_7fff_fffc, 1'b0, 32'h0,         4'h0, 0,  31'h7fff_fffc, 3,   32'h0123_4567, 1'b0};
        vecs[6] = '{34'h0_93ff_fff0, 1'b1, 32'hfeed_0001, 4'h8, 3,  31'h03ff_fff0, 0,   32'h89ab_cdef, 1'b0};
        vecs[7] = '{34'h0_9000_0040, 1'b0, 32'h0,         4'h0, 3,  31'h0040,      999, 32'h7777_7777, 1'b0};
        vecs[8] = '{34'h0_8000_1000, 1'b0, 32'h0,         4'h0, -1, 31'h0,         0,   32'h0,         1'b0};

        rst_n          = 1'b0;
        core_i.psel    = 1'b0;
        core_i.penable = 1'b0;
        core_i.pwrite  = 1'b0;
        core_i.paddr   = '0;
        core_i.pwdata  = '0;
        core_i.pwstrb  = '0;
        t.pready       = '0;
        t.pslverr      = '0;
        t.prdata       = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_state", dbg_state, 2'd0);
        check("rst_err", {err_valid, err_code, err_addr, err_cnt}, '0);
        check("rst_psel", t.psel, '0);
        check("rst_pready", {core_i.pready, core_i.pslverr, core_i.prdata}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven transfers, each followed by an idle cycle.
        for (int k = 0; k < 9; k++) begin
            xfer(vecs[k], 1'b0);
            idle_check();
        end

        // Random reads/writes to target 0.
        for (int k = 0; k < 8; k++) begin
            v.addr  = ADDR_W'($urandom() & 32'h7fff_fffc);
            v.wr    = 1'($urandom_range(0, 1));
            v.wdata = $urandom();
            v.strb  = 4'($urandom_range(0, 15));
            v.tgt   = 0;
            v.paddr = TGT_ADDR_W'(v.addr);
            v.waits = $urandom_range(0, 5);
            v.rdata = $urandom();
            v.terr  = 1'($urandom_range(0, 1));
            xfer(v, 1'b0);
            idle_check();
        end

        // 300 back-to-back unmapped accesses: err_cnt must saturate.
        v = vecs[2];
        for (int k = 0; k < 300; k++) begin
            v.addr = 34'h0_a000_0000 + ADDR_W'(k * 4);
            xfer(v, k > 0);
        end
        // SETUP to target 1 in the very next cycle after the last completion.
        v = '{34'h0_8000_0010, 1'b0, 32'h0, 4'h0, 1, 31'h0010, 1, 32'h1111_2222, 1'b0};
        xfer(v, 1'b1);
        idle_check();
        check("err_cnt_sat", err_cnt, 8'hff);

        // Reset in the middle of a stalled ACCESS phase.
        @(negedge clk);
        core_i.psel    = 1'b1;
        core_i.penable = 1'b0;
        core_i.pwrite  = 1'b0;
        core_i.paddr   = 34'h0_0000_0500;
        t.pready       = '0;
        repeat (3) begin
            @(negedge clk);
            core_i.penable = 1'b1;
        end
        #1;
        check("pre_rst_state", dbg_state, 2'd1);
        check("pre_rst_psel", t.psel, 4'b0001);
        @(negedge clk);
        rst_n          = 1'b0;
        core_i.psel    = 1'b0;
        core_i.penable = 1'b0;
        #1;
        check("mid_rst_state", dbg_state, 2'd0);
        check("mid_rst_err", {err_valid, err_code, err_addr, err_cnt}, '0);
        check("mid_rst_psel", t.psel, '0);
        check("mid_rst_pready", {core_i.pready, core_i.pslverr, core_i.prdata}, '0);
        exp_cnt  = 0;
        last_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        v = '{34'h0_0000_0200, 1'b0, 32'h0, 4'h0, 0, 31'h0200, 1, 32'h5a5a_a5a5, 1'b0};
        xfer(v, 1'b0);
        idle_check();

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL exp_q_leftover actual=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

endmodule
